// File: rtl/bsg_osc_cal_ctrl_pkg.sv
// Shared types and default calibration constants for the oscillator calibration sequencer.
// Imported by bsg_osc_cal_ctrl.
package bsg_osc_cal_ctrl_pkg;

   typedef enum logic [3:0] {
      eOscCalIdle,
      eOscCalApply,
      eOscCalSettle,
      eOscCalClear,
      eOscCalMeasure,
      eOscCalDrain,
      eOscCalCompare,
      eOscCalFinal,
      eOscCalDone
   } osc_cal_state_e;

   localparam int osc_cal_window_gp = 1024;
   localparam int osc_cal_settle_gp = 16;

   function automatic int osc_cal_max(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/bsg_osc_cal_ctrl.sv
// SAR calibration of the oscillator control code against a monitor-count target
// measured over a fixed reference window. Runs in the reference clock domain.
module bsg_osc_cal_ctrl
   import bsg_osc_cal_ctrl_pkg::*;
#(
   parameter int ctl_width_p     = 8,
   parameter int count_width_p   = 16,
   parameter int window_cycles_p = osc_cal_window_gp,
   parameter int settle_cycles_p = osc_cal_settle_gp
) (
   input  logic                     clk_i,
   input  logic                     async_reset_i,
   input  logic                     start_i,
   input  logic [count_width_p-1:0] target_i,
   input  logic [count_width_p-1:0] count_i,
   output logic [ctl_width_p-1:0]   ctl_o,
   output logic                     ctl_v_o,
   output logic                     div_clear_o,
   output logic                     div_enable_o,
   output logic                     busy_o,
   output logic                     done_o
);

   localparam int bit_w_lp    = (ctl_width_p > 1) ? $clog2(ctl_width_p) : 1;
   localparam int wait_max_lp = osc_cal_max(window_cycles_p, settle_cycles_p);
   localparam int cnt_w_lp    = $clog2(wait_max_lp + 1);

   localparam logic [cnt_w_lp-1:0] settle_load_lp = cnt_w_lp'(settle_cycles_p - 1);
   localparam logic [cnt_w_lp-1:0] window_load_lp = cnt_w_lp'(window_cycles_p - 1);

   osc_cal_state_e               state_q, state_d;
   logic [ctl_width_p-1:0]       code_q, code_d;
   logic [bit_w_lp-1:0]          bit_q, bit_d;
   logic [count_width_p-1:0]     target_q, target_d;
   logic [cnt_w_lp-1:0]          cnt_q, cnt_d;
   logic [bit_w_lp-1:0]          bit_m1;

   assign bit_m1 = bit_q - 1'b1;
   assign ctl_o  = code_q;

   always_ff @(posedge clk_i or posedge async_reset_i) begin
      if (async_reset_i) begin
         state_q  <= eOscCalIdle;
         code_q   <= '0;
         bit_q    <= '0;
         target_q <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         code_q   <= code_d;
         bit_q    <= bit_d;
         target_q <= target_d;
         cnt_q    <= cnt_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      code_d       = code_q;
      bit_d        = bit_q;
      target_d     = target_q;
      cnt_d        = cnt_q;
      ctl_v_o      = 1'b0;
      div_clear_o  = 1'b0;
      div_enable_o = 1'b0;
      busy_o       = 1'b1;
      done_o       = 1'b0;

      unique case (state_q)
         eOscCalIdle, eOscCalDone: begin
            busy_o = 1'b0;
            done_o = (state_q == eOscCalDone);
            if (start_i) begin
               target_d = target_i;
               code_d   = ctl_width_p'(1) << (ctl_width_p - 1);
               bit_d    = bit_w_lp'(ctl_width_p - 1);
               state_d  = eOscCalApply;
            end
         end
         eOscCalApply: begin
            ctl_v_o = 1'b1;
            cnt_d   = settle_load_lp;
            state_d = eOscCalSettle;
         end
         // Each wait state holds until the shared down-counter reaches zero,
         // then preloads it for the next timed state.
         eOscCalSettle: begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == '0) begin
               cnt_d   = settle_load_lp;
               state_d = eOscCalClear;
            end
         end
         eOscCalClear: begin
            div_clear_o = 1'b1;
            cnt_d       = cnt_q - 1'b1;
            if (cnt_q == '0) begin
               cnt_d   = window_load_lp;
               state_d = eOscCalMeasure;
            end
         end
         eOscCalMeasure: begin
            div_enable_o = 1'b1;
            cnt_d        = cnt_q - 1'b1;
            if (cnt_q == '0) begin
               cnt_d   = settle_load_lp;
               state_d = eOscCalDrain;
            end
         end
         eOscCalDrain: begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == '0) begin
               cnt_d   = '0;
               state_d = eOscCalCompare;
            end
         end
         eOscCalCompare: begin
            // Too fast keeps the bit; equality or slower clears it.
            if (count_i <= target_q) begin
               code_d[bit_q] = 1'b0;
            end
            if (bit_q != '0) begin
               code_d[bit_m1] = 1'b1;
               bit_d          = bit_m1;
               state_d        = eOscCalApply;
            end else begin
               state_d = eOscCalFinal;
            end
         end
         eOscCalFinal: begin
            ctl_v_o = 1'b1;
            state_d = eOscCalDone;
         end
         default: begin
            busy_o  = 1'b0;
            state_d = eOscCalIdle;
         end
      endcase
   end

endmodule

// File: tb/tb_bsg_osc_cal_ctrl.sv
// Randomized self-checking bench for bsg_osc_cal_ctrl: a linear oscillator model
// drives count_i, and the expected search result is derived by brute force.
module tb_bsg_osc_cal_ctrl;

   localparam int CW = 4;
   localparam int NW = 16;
   localparam int WIN = 32;
   localparam int SET = 4;
   localparam int L = 2 + 3 * SET + WIN;
   localparam int RUN = CW * L + 1;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          start_i = 1'b0;
   logic [NW-1:0] target_i = '0;
   logic [NW-1:0] count_i = '0;
   logic [CW-1:0] ctl_o;
   logic          ctl_v_o, div_clear_o, div_enable_o, busy_o, done_o;

   int n_tests = 0;
   int n_fail  = 0;

   int base_g  = 200;
   int slope_g = 10;
   int tgt_g   = 0;
   int since   = 100;

   always #5 clk = ~clk;

   bsg_osc_cal_ctrl #(
      .ctl_width_p    (CW),
      .count_width_p  (NW),
      .window_cycles_p(WIN),
      .settle_cycles_p(SET)
   ) dut (
      .clk_i        (clk),
      .async_reset_i(rst),
      .start_i      (start_i),
      .target_i     (target_i),
      .count_i      (count_i),
      .ctl_o        (ctl_o),
      .ctl_v_o      (ctl_v_o),
      .div_clear_o  (div_clear_o),
      .div_enable_o (div_enable_o),
      .busy_o       (busy_o),
      .done_o       (done_o)
   );

   function automatic int count_of(input int c);
      int v;
      v = base_g - slope_g * c;
      return (v < 0) ? 0 : v;
   endfunction

   // Largest code still too fast for the target; 0 if none is.
   function automatic int expected_final(input int tgt);
      int r;
      r = 0;
      for (int c = 0; c < (1 << CW); c++) begin
         if (count_of(c) > tgt) r = c;
      end
      return r;
   endfunction

   task automatic check_eq(input string tag, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   // The true count is only presented in the cycle settle+1 after enable falls;
   // any other cycle carries a value that would invert the decision.
   always @(negedge clk) begin
      int good;
      if (div_enable_o) since = 0;
      else if (since < 100) since++;
      good = count_of(int'(ctl_o));
      if (since == SET + 1) count_i = NW'(good);
      else count_i = (good > tgt_g) ? '0 : '1;
   end

   task automatic check_idle_outputs(input string tag);
      check_eq({tag, "_ctl"},   int'(ctl_o), 0);
      check_eq({tag, "_ctlv"},  int'(ctl_v_o), 0);
      check_eq({tag, "_clr"},   int'(div_clear_o), 0);
      check_eq({tag, "_en"},    int'(div_enable_o), 0);
      check_eq({tag, "_busy"},  int'(busy_o), 0);
      check_eq({tag, "_done"},  int'(done_o), 0);
   endtask

   task automatic run_cal(input int tgt, input bit mid_start);
      int strobes[$];
      int runs[$];
      int en_run, overlap, busy_n, exp_f, trial;
      strobes = {};
      runs    = {};
      en_run  = 0;
      overlap = 0;
      busy_n  = 0;
      tgt_g   = tgt;
      exp_f   = expected_final(tgt);

      @(negedge clk);
      start_i  = 1'b1;
      target_i = NW'(tgt);
      @(negedge clk);
      start_i  = 1'b0;
      check_eq("start_busy", int'(busy_o), 1);
      check_eq("start_ctlv", int'(ctl_v_o), 1);
      check_eq("start_ctl",  int'(ctl_o), 1 << (CW - 1));
      check_eq("start_done", int'(done_o), 0);

      for (int k = 0; k < 400; k++) begin
         if (!busy_o) break;
         busy_n++;
         if (ctl_v_o) strobes.push_back(int'(ctl_o));
         if (div_enable_o) en_run++;
         else if (en_run != 0) begin
            runs.push_back(en_run);
            en_run = 0;
         end
         if (div_clear_o && div_enable_o) overlap++;
         @(negedge clk);
         start_i = 1'b0;
         if (mid_start && busy_n == 110) begin
            start_i  = 1'b1;
            target_i = NW'($urandom_range(0, 400));
         end
      end
      start_i = 1'b0;

      check_eq("run_len",  busy_n, RUN);
      check_eq("done",     int'(done_o), 1);
      check_eq("busy_end", int'(busy_o), 0);
      check_eq("final",    int'(ctl_o), exp_f);
      check_eq("overlap",  overlap, 0);
      check_eq("n_strobe", strobes.size(), CW + 1);
      for (int k = CW - 1; k >= 0; k--) begin
         trial = (exp_f & ~((1 << (k + 1)) - 1)) | (1 << k);
         if (strobes.size() > CW - 1 - k)
            check_eq("trial", strobes[CW - 1 - k], trial);
      end
      if (strobes.size() > CW) check_eq("final_strobe", strobes[CW], exp_f);
      check_eq("n_windows", runs.size(), CW);
      foreach (runs[i]) check_eq("window_len", runs[i], WIN);
   endtask

   initial begin
      rst = 1'b1;
      #1;
      check_idle_outputs("reset");
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_idle_outputs("post_reset");

      // Abort a run mid-MEASURE with an async reset.
      base_g  = 200;
      slope_g = 10;
      tgt_g   = 120;
      start_i = 1'b1;
      target_i = 16'd120;
      @(negedge clk);
      start_i = 1'b0;
      repeat (20) @(negedge clk);
      check_eq("pre_reset_en", int'(div_enable_o), 1);
      #2 rst = 1'b1;
      #1;
      check_idle_outputs("mid_reset");
      @(negedge clk);
      rst = 1'b0;

      run_cal(120, 1'b0);
      run_cal(255, 1'b0);
      run_cal(0, 1'b0);
      run_cal(130, 1'b1);

      for (int r = 0; r < 6; r++) begin
         base_g  = int'($urandom_range(150, 400));
         slope_g = int'($urandom_range(1, 20));
         run_cal(int'($urandom_range(0, 420)), r[0]);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
